term_esc_parser: RTL and testbench
==================================

// Module: term_esc_parser
// PURPOSE
//  Byte-stream interpreter directly downstream of the UART receiver. Consumes each received
//  byte (rx_data qualified by the 1-cycle rx_complete strobe) and emits either a printable
//  character write or a decoded terminal command (control codes, VT100 CSI sequences) to the
//  screen/cursor logic. No backpressure; the sink accepts one event per cycle.
// PARAMETERS
//  ARG_W      8   width of each CSI numeric argument; accumulation saturates at 2**ARG_W-1
//  TAB_STOP   8   column spacing reported with CMD_TAB in cmd_arg0
// PORTS
//  clk100      in   1      system clock, single clock domain
//  resetn      in   1      synchronous reset, active low
//  rx_data     in   8      received byte, valid when rx_complete=1
//  rx_complete in   1      1-cycle strobe, one per byte
//  char_valid  out  1      1-cycle strobe: char_data is a printable char to place at cursor
//  char_data   out  8      printable byte 0x20..0x7E
//  cmd_valid   out  1      1-cycle strobe: cmd_op/cmd_arg0/cmd_arg1 valid
//  cmd_op      out  4      command code (term_pkg::CMD_*)
//  cmd_arg0    out  ARG_W  first argument (row / count / mode)
//  cmd_arg1    out  ARG_W  second argument (column), 0 if unused
// BEHAVIOUR
//  - Reset (resetn=0 at clk100 edge): state=GROUND, args cleared, all outputs 0. Reset during a
//    sequence discards it; no event is emitted for the partial sequence.
//  - Latency: every event is registered; strobe asserts exactly 1 cycle after the rx_complete
//    cycle, for 1 cycle. char_valid and cmd_valid never assert together. Data outputs hold
//    their last value between strobes.
//  - States: GROUND, ESC, CSI, CSI_IGN.
//  - GROUND: 0x20..0x7E -> char event. 0x0D->CMD_CR, 0x0A->CMD_LF, 0x08->CMD_BS,
//    0x09->CMD_TAB(arg0=TAB_STOP), 0x1B->ESC. All other bytes (incl. 0x7F, >=0x80) ignored.
//  - ESC: '[' -> CSI with arg0=arg1=0, arg index=0. 'c' -> CMD_RIS, GROUND. 0x1B stays ESC.
//    Any other byte -> GROUND, no event.
//  - CSI: '0'..'9' -> arg[idx] = arg[idx]*10 + digit, saturating at 2**ARG_W-1 (never wraps).
//    ';' -> idx+1; ';' when idx already 1 -> CSI_IGN. Final byte 0x40..0x7E -> decode, GROUND.
//    Other 0x20..0x3F (e.g. '?') -> CSI_IGN.
//  - CSI_IGN: swallow bytes until a final byte 0x40..0x7E, then GROUND, no event.
//  - In ESC/CSI/CSI_IGN: 0x18 (CAN) or 0x1A (SUB) -> GROUND, no event; 0x1B -> ESC (restart).
//    C0 controls 0x08/0x09/0x0A/0x0D inside CSI are executed immediately (event emitted) and
//    the sequence continues unchanged.
//  - Final decode: 'A' CUU, 'B' CUD, 'C' CUF, 'D' CUB (arg0=count, 0 -> 1);
//    'H' or 'f' CUP (arg0=row, arg1=col, each 0 -> 1, 1-based); 'J' ED, 'K' EL (arg0=mode
//    as received, 0 allowed); 'm' see CONFIGURATION; any other final -> no event.
// CONFIGURATION
//  TERM_SGR_EN defined: 'm' emits CMD_SGR with arg0=param0, arg1=param1 (raw, 0 allowed;
//    "ESC[m" gives arg0=0).
//  TERM_SGR_EN undefined: 'm' sequences are fully consumed, no event; CMD_SGR is never driven.
// STRUCTURE
//  term_pkg: CMD_* localparams (CR=0, LF=1, BS=2, TAB=3, CUU=4, CUD=5, CUF=6, CUB=7, CUP=8,
//    ED=9, EL=10, SGR=11, RIS=12), parser state encoding, ASCII constants (ESC, CAN, SUB).
//  Sub-module term_csi_arg: one ARG_W-bit register with clear/accumulate-digit inputs and
//    saturating x10+d; instantiated twice (arg0, arg1).
// TESTING
//  - "Hi" (0x48,0x69) -> two char strobes, each 1 cycle after its rx_complete; cmd_valid=0.
//  - ESC [ 1 2 ; 4 0 H -> single CMD_CUP, arg0=12, arg1=40; no char strobes for any byte.
//  - ESC [ A and ESC [ 0 C -> CMD_CUU arg0=1, CMD_CUF arg0=1; ESC [ 2 J -> CMD_ED arg0=2.
//  - ESC [ 9 9 9 9 B (ARG_W=8) -> CMD_CUD arg0=255; ESC [ 1;2;3 H -> no event, then 'x' -> char.
//  - ESC [ 5 0x18 'A' -> no cmd, char 'A'; ESC [ 3 ESC [ 4 D -> CMD_CUB arg0=4 only.
//  - ESC [ 3 1 ; 4 m -> CMD_SGR 31/4 with TERM_SGR_EN, no event without; resetn low after
//    ESC [ 7 then 'K' -> char 'K', no CMD_EL.

Source files
------------

// File: rtl/term_pkg.sv
// Shared definitions for the terminal escape parser: command codes, parser states, ASCII bytes.
package term_pkg;

  localparam logic [3:0] CMD_CR  = 4'd0;
  localparam logic [3:0] CMD_LF  = 4'd1;
  localparam logic [3:0] CMD_BS  = 4'd2;
  localparam logic [3:0] CMD_TAB = 4'd3;
  localparam logic [3:0] CMD_CUU = 4'd4;
  localparam logic [3:0] CMD_CUD = 4'd5;
  localparam logic [3:0] CMD_CUF = 4'd6;
  localparam logic [3:0] CMD_CUB = 4'd7;
  localparam logic [3:0] CMD_CUP = 4'd8;
  localparam logic [3:0] CMD_ED  = 4'd9;
  localparam logic [3:0] CMD_EL  = 4'd10;
  localparam logic [3:0] CMD_SGR = 4'd11;
  localparam logic [3:0] CMD_RIS = 4'd12;

  typedef enum logic [1:0] {StGround, StEsc, StCsi, StCsiIgn} term_state_e;

  localparam logic [7:0] ASCII_BS   = 8'h08;
  localparam logic [7:0] ASCII_HT   = 8'h09;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_CAN  = 8'h18;
  localparam logic [7:0] ASCII_SUB  = 8'h1A;
  localparam logic [7:0] ASCII_ESC  = 8'h1B;
  localparam logic [7:0] ASCII_SEMI = 8'h3B;
  localparam logic [7:0] ASCII_LBR  = 8'h5B;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  function automatic logic is_final(input logic [7:0] b);
    return (b >= 8'h40) && (b <= 8'h7E);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic is_c0_exec(input logic [7:0] b);
    return (b == ASCII_BS) || (b == ASCII_HT) || (b == ASCII_LF) || (b == ASCII_CR);
  endfunction

  function automatic logic [3:0] c0_op(input logic [7:0] b);
    unique case (b)
      ASCII_CR: return CMD_CR;
      ASCII_LF: return CMD_LF;
      ASCII_BS: return CMD_BS;
      default:  return CMD_TAB;
    endcase
  endfunction

endpackage

// File: rtl/term_esc_parser_if.sv
// Byte-in / event-out bundle between the UART receiver, the parser and the screen logic.
interface term_esc_parser_if #(
  parameter int unsigned ARG_W = 8
);
  logic [7:0]       rx_data;
  logic             rx_complete;
  logic             char_valid;
  logic [7:0]       char_data;
  logic             cmd_valid;
  logic [3:0]       cmd_op;
  logic [ARG_W-1:0] cmd_arg0;
  logic [ARG_W-1:0] cmd_arg1;

  modport master (
    output rx_data, rx_complete,
    input  char_valid, char_data, cmd_valid, cmd_op, cmd_arg0, cmd_arg1
  );

  modport slave (
    input  rx_data, rx_complete,
    output char_valid, char_data, cmd_valid, cmd_op, cmd_arg0, cmd_arg1
  );
endinterface

// File: rtl/term_csi_arg.sv
// One CSI numeric argument: clear, or accumulate a decimal digit as x10+d saturating at all-ones.
module term_csi_arg #(
  parameter int unsigned ARG_W = 8
) (
  input  logic             clk100,
  input  logic             resetn,
  input  logic             clr,
  input  logic             acc,
  input  logic [3:0]       digit,
  output logic [ARG_W-1:0] value
);
  localparam int unsigned SumW = ARG_W + 4;
  localparam logic [SumW-1:0] SumMax = {4'b0000, {ARG_W{1'b1}}};

  logic [ARG_W-1:0] value_q, value_d;
  logic [SumW-1:0]  sum;

  always_comb begin
    // 4 extra bits hold (2**ARG_W-1)*10+9 without overflow
    sum     = SumW'(value_q) * SumW'(10) + SumW'(digit);
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (acc) begin
      value_d = (sum > SumMax) ? '1 : sum[ARG_W-1:0];
    end
  end

  always_ff @(posedge clk100) begin
    if (!resetn) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/term_esc_parser.sv
// UART byte-stream interpreter: printable chars, C0 controls and VT100 CSI cursor commands.
// Optional feature macro TERM_SGR_EN: decode 'm' (SGR) into CMD_SGR events.
module term_esc_parser
  import term_pkg::*;
#(
  parameter int unsigned ARG_W    = 8,
  parameter int unsigned TAB_STOP = 8
) (
  input logic              clk100,
  input logic              resetn,
  term_esc_parser_if.slave bus
);
  localparam logic [ARG_W-1:0] TabArg = ARG_W'(TAB_STOP);

  term_state_e      state_q;
  logic             idx_q;
  logic             char_valid_q, cmd_valid_q;
  logic [7:0]       char_data_q;
  logic [3:0]       cmd_op_q;
  logic [ARG_W-1:0] cmd_arg0_q, cmd_arg1_q;

  logic [7:0]       b;
  logic             rx;
  logic             csi_digit, args_clr;
  logic [ARG_W-1:0] arg0, arg1;

  assign b         = bus.rx_data;
  assign rx        = bus.rx_complete;
  assign csi_digit = rx && (state_q == StCsi) && is_digit(b);
  assign args_clr  = rx && (state_q == StEsc) && (b == ASCII_LBR);

  term_csi_arg #(.ARG_W(ARG_W)) u_arg0 (
    .clk100 (clk100),
    .resetn (resetn),
    .clr    (args_clr),
    .acc    (csi_digit && !idx_q),
    .digit  (b[3:0]),
    .value  (arg0)
  );

  term_csi_arg #(.ARG_W(ARG_W)) u_arg1 (
    .clk100 (clk100),
    .resetn (resetn),
    .clr    (args_clr),
    .acc    (csi_digit && idx_q),
    .digit  (b[3:0]),
    .value  (arg1)
  );

  function automatic logic [ARG_W-1:0] min1(input logic [ARG_W-1:0] v);
    return (v == '0) ? ARG_W'(1) : v;
  endfunction

  always_ff @(posedge clk100) begin
    if (!resetn) begin
      state_q      <= StGround;
      idx_q        <= 1'b0;
      char_valid_q <= 1'b0;
      char_data_q  <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_op_q     <= '0;
      cmd_arg0_q   <= '0;
      cmd_arg1_q   <= '0;
    end else begin
      char_valid_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      if (rx) begin
        unique case (state_q)
          StGround: begin
            if (is_printable(b)) begin
              char_valid_q <= 1'b1;
              char_data_q  <= b;
            end else if (is_c0_exec(b)) begin
              cmd_valid_q <= 1'b1;
              cmd_op_q    <= c0_op(b);
              cmd_arg0_q  <= (b == ASCII_HT) ? TabArg : '0;
              cmd_arg1_q  <= '0;
            end else if (b == ASCII_ESC) begin
              state_q <= StEsc;
            end
          end
          StEsc: begin
            if (b == ASCII_LBR) begin
              state_q <= StCsi;
              idx_q   <= 1'b0;
            end else if (b == "c") begin
              cmd_valid_q <= 1'b1;
              cmd_op_q    <= CMD_RIS;
              cmd_arg0_q  <= '0;
              cmd_arg1_q  <= '0;
              state_q     <= StGround;
            end else if (b != ASCII_ESC) begin
              state_q <= StGround;
            end
          end
          StCsi: begin
            if ((b == ASCII_CAN) || (b == ASCII_SUB)) begin
              state_q <= StGround;
            end else if (b == ASCII_ESC) begin
              state_q <= StEsc;
            end else if (is_c0_exec(b)) begin
              // Executed in place; the sequence carries on around it
              cmd_valid_q <= 1'b1;
              cmd_op_q    <= c0_op(b);
              cmd_arg0_q  <= (b == ASCII_HT) ? TabArg : '0;
              cmd_arg1_q  <= '0;
            end else if (is_digit(b)) begin
              state_q <= StCsi;
            end else if (b == ASCII_SEMI) begin
              if (idx_q) state_q <= StCsiIgn;
              else       idx_q   <= 1'b1;
            end else if (is_final(b)) begin
              state_q <= StGround;
              case (b)
                "A", "B", "C", "D": begin
                  cmd_valid_q <= 1'b1;
                  cmd_op_q    <= (b == "A") ? CMD_CUU : (b == "B") ? CMD_CUD :
                                 (b == "C") ? CMD_CUF : CMD_CUB;
                  cmd_arg0_q  <= min1(arg0);
                  cmd_arg1_q  <= '0;
                end
                "H", "f": begin
                  cmd_valid_q <= 1'b1;
                  cmd_op_q    <= CMD_CUP;
                  cmd_arg0_q  <= min1(arg0);
                  cmd_arg1_q  <= min1(arg1);
                end
                "J", "K": begin
                  cmd_valid_q <= 1'b1;
                  cmd_op_q    <= (b == "J") ? CMD_ED : CMD_EL;
                  cmd_arg0_q  <= arg0;
                  cmd_arg1_q  <= '0;
                end
`ifdef TERM_SGR_EN
                "m": begin
                  cmd_valid_q <= 1'b1;
                  cmd_op_q    <= CMD_SGR;
                  cmd_arg0_q  <= arg0;
                  cmd_arg1_q  <= arg1;
                end
`endif
                default: ;
              endcase
            end else if (b >= 8'h20) begin
              // Remaining 0x20..0x3F: private/intermediate bytes we do not support
              state_q <= StCsiIgn;
            end
          end
          StCsiIgn: begin
            if ((b == ASCII_CAN) || (b == ASCII_SUB) || is_final(b)) begin
              state_q <= StGround;
            end else if (b == ASCII_ESC) begin
              state_q <= StEsc;
            end
          end
          default: state_q <= StGround;
        endcase
      end
    end
  end

  assign bus.char_valid = char_valid_q;
  assign bus.char_data  = char_data_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd_op     = cmd_op_q;
  assign bus.cmd_arg0   = cmd_arg0_q;
  assign bus.cmd_arg1   = cmd_arg1_q;

endmodule

// File: tb/tb_term_esc_parser.sv
// Directed, table-driven bench for term_esc_parser; honours TERM_SGR_EN for the 'm' vectors.
module tb_term_esc_parser;

  localparam logic [3:0] OpCr = 4'd0, OpLf = 4'd1, OpBs = 4'd2, OpTab = 4'd3;
  localparam logic [3:0] OpCuu = 4'd4, OpCud = 4'd5, OpCuf = 4'd6, OpCub = 4'd7;
  localparam logic [3:0] OpCup = 4'd8, OpEd = 4'd9, OpEl = 4'd10, OpSgr = 4'd11;
  localparam logic [3:0] OpRis = 4'd12;

  typedef struct {
    logic [7:0] data;
    logic       exp_char;
    logic [7:0] exp_cdata;
    logic       exp_cmd;
    logic [3:0] exp_op;
    logic [7:0] exp_a0;
    logic [7:0] exp_a1;
  } vec_t;

  logic clk100 = 1'b0;
  logic resetn = 1'b0;
  always #5 clk100 = ~clk100;

  term_esc_parser_if #(.ARG_W(8)) bus ();

  term_esc_parser #(
    .ARG_W    (8),
    .TAB_STOP (8)
  ) dut (
    .clk100 (clk100),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic vn(input logic [7:0] b);
    vecs.push_back('{b, 1'b0, 8'h00, 1'b0, 4'd0, 8'd0, 8'd0});
  endtask

  task automatic vc(input logic [7:0] b);
    vecs.push_back('{b, 1'b1, b, 1'b0, 4'd0, 8'd0, 8'd0});
  endtask

  task automatic vm(input logic [7:0] b, input logic [3:0] op, input logic [7:0] a0,
                    input logic [7:0] a1);
    vecs.push_back('{b, 1'b0, 8'h00, 1'b1, op, a0, a1});
  endtask

  task automatic vcsi();
    vn(8'h1B);
    vn(8'h5B);
  endtask

  // Compare current outputs; data fields checked only where a strobe is expected
  task automatic check(input string name, input logic ec, input logic [7:0] cd, input logic em,
                       input logic [3:0] op, input logic [7:0] a0, input logic [7:0] a1);
    logic ok;
    ok = (bus.char_valid === ec) && (bus.cmd_valid === em) &&
         (!ec || (bus.char_data === cd)) &&
         (!em || ((bus.cmd_op === op) && (bus.cmd_arg0 === a0) && (bus.cmd_arg1 === a1)));
    n_checks++;
    if (ok) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got cv=%b cd=%h mv=%b op=%0d a0=%0d a1=%0d, want cv=%b cd=%h mv=%b op=%0d a0=%0d a1=%0d",
               name, bus.char_valid, bus.char_data, bus.cmd_valid, bus.cmd_op, bus.cmd_arg0,
               bus.cmd_arg1, ec, cd, em, op, a0, a1);
    end
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if ({bus.char_valid, bus.char_data, bus.cmd_valid, bus.cmd_op, bus.cmd_arg0, bus.cmd_arg1}
        === '0) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got cv=%b cd=%h mv=%b op=%0d a0=%0d a1=%0d, want all outputs 0",
               name, bus.char_valid, bus.char_data, bus.cmd_valid, bus.cmd_op, bus.cmd_arg0,
               bus.cmd_arg1);
    end
  endtask

  // Strobe rx for one cycle; on return we sit in the cycle right after it
  task automatic send(input logic [7:0] b);
    @(negedge clk100);
    bus.rx_data     = b;
    bus.rx_complete = 1'b1;
    @(negedge clk100);
    bus.rx_complete = 1'b0;
  endtask

  initial begin
    bus.rx_data     = 8'h00;
    bus.rx_complete = 1'b0;

    vc(8'h48); vc(8'h69);                                        // "Hi"
    vcsi(); vn("1"); vn("2"); vn(";"); vn("4"); vn("0"); vm("H", OpCup, 8'd12, 8'd40);
    vcsi(); vm("A", OpCuu, 8'd1, 8'd0);
    vcsi(); vn("0"); vm("C", OpCuf, 8'd1, 8'd0);
    vcsi(); vn("2"); vm("J", OpEd, 8'd2, 8'd0);
    vcsi(); vn("9"); vn("9"); vn("9"); vn("9"); vm("B", OpCud, 8'd255, 8'd0);
    vcsi(); vn("1"); vn(";"); vn("2"); vn(";"); vn("3"); vn("H"); vc("x");
    vcsi(); vn("5"); vn(8'h18); vc("A");
    vcsi(); vn("3"); vcsi(); vn("4"); vm("D", OpCub, 8'd4, 8'd0);
    vcsi(); vn("3"); vn("1"); vn(";"); vn("4");
`ifdef TERM_SGR_EN
    vm("m", OpSgr, 8'd31, 8'd4);
    vcsi(); vm("m", OpSgr, 8'd0, 8'd0);
`else
    vn("m");
    vcsi(); vn("m");
`endif
    vm(8'h0D, OpCr, 8'd0, 8'd0); vm(8'h0A, OpLf, 8'd0, 8'd0);
    vm(8'h08, OpBs, 8'd0, 8'd0); vm(8'h09, OpTab, 8'd8, 8'd0);
    vn(8'h7F); vn(8'h80); vn(8'h00);
    vn(8'h1B); vm("c", OpRis, 8'd0, 8'd0);
    vcsi(); vn("5"); vm(8'h0D, OpCr, 8'd0, 8'd0); vm("A", OpCuu, 8'd5, 8'd0);
    vn(8'h1B); vn(8'h1B); vn(8'h5B); vm("B", OpCud, 8'd1, 8'd0);
    vcsi(); vm("H", OpCup, 8'd1, 8'd1);
    vcsi(); vn("7"); vm("f", OpCup, 8'd7, 8'd1);
    vcsi(); vm("K", OpEl, 8'd0, 8'd0);
    vcsi(); vn("?"); vn("2"); vn("5"); vn("h"); vc("h");
    vn(8'h1B); vn("X"); vc("X");
    vcsi(); vn("4"); vn(8'h1A); vc("B");

    repeat (3) @(negedge clk100);
    check_zero("reset_state");
    resetn = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i].data);
      check($sformatf("vec[%0d] byte %h", i, vecs[i].data), vecs[i].exp_char,
            vecs[i].exp_cdata, vecs[i].exp_cmd, vecs[i].exp_op, vecs[i].exp_a0, vecs[i].exp_a1);
    end

    // Strobe lasts one cycle; command fields hold after it
    send(8'h1B); send(8'h5B); send("6"); send("A");
    check("cuu6", 1'b0, 8'h00, 1'b1, OpCuu, 8'd6, 8'd0);
    @(negedge clk100);
    check("strobe_drop", 1'b0, 8'h00, 1'b0, 4'd0, 8'd0, 8'd0);
    send(8'h7F);
    n_checks++;
    if (!bus.cmd_valid && bus.cmd_op === OpCuu && bus.cmd_arg0 === 8'd6) begin
      n_pass++;
    end else begin
      $display("FAIL hold: got mv=%b op=%0d a0=%0d, want mv=0 op=%0d a0=6",
               bus.cmd_valid, bus.cmd_op, bus.cmd_arg0, OpCuu);
    end

    // Reset in mid-sequence discards it
    send(8'h1B); send(8'h5B); send("7");
    @(negedge clk100);
    resetn = 1'b0;
    @(negedge clk100);
    check_zero("mid_seq_reset");
    resetn = 1'b1;
    send("K");
    check("after_reset_K", 1'b1, "K", 1'b0, 4'd0, 8'd0, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
